// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS-subset control FSM (optional JR via MC_JR_EN)
module multicycle_controller #(
  parameter int OPW = 6,
  parameter int FW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  func,
  input  logic           zero,
  output logic           PCWrite,
  output logic           IorD,
  output logic           MemRead,
  output logic           saveMem,
  output logic           IRWrite,
  output logic [1:0]     RegDst,
  output logic           MemToReg,
  output logic           PCToReg,
  output logic           saveReg,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           instrDone,
  output logic           illegalOp,
  output logic [3:0]     state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB,
    BRANCH, IEXEC, IWB, JUMP, JALS, JR
  } st_t;
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(6'b001001);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(6'b001010);
  localparam logic [FW-1:0]  FN_JR   = FW'(6'b001000);
`ifdef MC_JR_EN
  localparam bit JR_EN = 1'b1;
`else
  localparam bit JR_EN = 1'b0;
`endif
  st_t st;
  logic is_mem, is_br, is_imm, is_jr, legal;
  assign is_mem = opcode == OP_LW || opcode == OP_SW;
  assign is_br  = opcode == OP_BEQ || opcode == OP_BNE;
  assign is_imm = opcode == OP_ADDI || opcode == OP_SUBI || opcode == OP_SLTI;
  assign is_jr  = JR_EN && opcode == OP_R && func == FN_JR;
  assign legal  = is_mem || is_br || is_imm || opcode == OP_R || opcode == OP_J || opcode == OP_JAL;
  assign state  = st;
  // state sequencing; the IR keeps opcode stable for the whole instruction
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= FETCH;
    else
      case (st)
        FETCH:  st <= DECODE;
        DECODE: st <= is_mem ? MEMADR :
                      is_jr ? JR :
                      opcode == OP_R ? REXEC :
                      is_br ? BRANCH :
                      is_imm ? IEXEC :
                      opcode == OP_J ? JUMP :
                      opcode == OP_JAL ? JALS : FETCH;
        MEMADR: st <= opcode == OP_LW ? MEMRD : MEMWR;
        MEMRD:  st <= MEMWB;
        REXEC:  st <= RWB;
        IEXEC:  st <= IWB;
        default: st <= FETCH;
      endcase
  // state decode; everything held low while rst is asserted so no write strobe can leak
  always_comb begin
    PCWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; saveMem = 1'b0; IRWrite = 1'b0;
    RegDst = 2'b00; MemToReg = 1'b0; PCToReg = 1'b0; saveReg = 1'b0; ALUSrcA = 1'b0;
    ALUSrcB = 2'b00; ALUOp = 2'b00; PCSrc = 2'b00; instrDone = 1'b0; illegalOp = 1'b0;
    if (!rst)
      case (st)
        FETCH:  begin MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'b01; PCWrite = 1'b1; end
        DECODE: begin ALUSrcB = 2'b11; illegalOp = !legal; end
        MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
        MEMWB:  begin MemToReg = 1'b1; saveReg = 1'b1; instrDone = 1'b1; end
        MEMWR:  begin saveMem = 1'b1; IorD = 1'b1; instrDone = 1'b1; end
        REXEC:  begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        RWB:    begin RegDst = 2'b01; saveReg = 1'b1; instrDone = 1'b1; end
        BRANCH: begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; instrDone = 1'b1; PCWrite = opcode == OP_BNE ? !zero : zero; end
        IEXEC:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = opcode == OP_SUBI ? 2'b01 : opcode == OP_SLTI ? 2'b11 : 2'b00; end
        IWB:    begin saveReg = 1'b1; instrDone = 1'b1; end
        JUMP:   begin PCSrc = 2'b10; PCWrite = 1'b1; instrDone = 1'b1; end
        JALS:   begin PCSrc = 2'b10; PCWrite = 1'b1; RegDst = 2'b10; PCToReg = 1'b1; saveReg = 1'b1; instrDone = 1'b1; end
        JR:     if (JR_EN) begin PCSrc = 2'b11; PCWrite = 1'b1; instrDone = 1'b1; end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  typedef struct packed {
    logic pcw, iord, mr, sm, irw;
    logic [1:0] rd;
    logic m2r, p2r, sr, asa;
    logic [1:0] asb, aop, pcs;
    logic done, ill;
    logic [3:0] st;
  } ov_t;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic PCWrite, IorD, MemRead, saveMem, IRWrite, MemToReg, PCToReg, saveReg, ALUSrcA, instrDone, illegalOp;
  logic [1:0] RegDst, ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
  ov_t act;
  ov_t exp_q[$];
  string tag_q[$];
  ov_t seq[$];
  int tests = 0, fails = 0;
  ov_t z_v, fetch_v, decode_v, ill_v, memadr_v, memrd_v, memwb_v, memwr_v, rexec_v, rwb_v;
  ov_t br1_v, br0_v, isub_v, islt_v, iadd_v, iwb_v, jump_v, jal_v, jr_v;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .saveMem(saveMem), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .PCToReg(PCToReg), .saveReg(saveReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .instrDone(instrDone), .illegalOp(illegalOp), .state(state)
  );

  assign act = {PCWrite, IorD, MemRead, saveMem, IRWrite, RegDst, MemToReg, PCToReg, saveReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, instrDone, illegalOp, state};

  always #5 clk = ~clk;

  // columns: st pcw iord mr sm irw rd m2r p2r sr asa asb aop pcs done ill
  function automatic ov_t mk(logic [3:0] st, logic pcw, logic iord, logic mr, logic sm, logic irw,
                             logic [1:0] rd, logic m2r, logic p2r, logic sr, logic asa,
                             logic [1:0] asb, logic [1:0] aop, logic [1:0] pcs, logic done, logic ill);
    return {pcw, iord, mr, sm, irw, rd, m2r, p2r, sr, asa, asb, aop, pcs, done, ill, st};
  endfunction

  // monitor: one expected vector per clock, checked mid-cycle
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      ov_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", t, act, act.st, e, e.st);
      end
    end

  task automatic go(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic zf, input int n);
    opcode = op; func = fn; zero = zf;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(seq[i]);
      tag_q.push_back($sformatf("%s.c%0d", tag, i + 1));
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input string tag, input int n);
    rst = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(z_v);
      tag_q.push_back($sformatf("%s.r%0d", tag, i + 1));
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    z_v      = mk(0, 0,0,0,0,0, 2'b00, 0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    fetch_v  = mk(0, 1,0,1,0,1, 2'b00, 0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    decode_v = mk(1, 0,0,0,0,0, 2'b00, 0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
    ill_v    = mk(1, 0,0,0,0,0, 2'b00, 0,0,0,0, 2'b11, 2'b00, 2'b00, 0,1);
    memadr_v = mk(2, 0,0,0,0,0, 2'b00, 0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    memrd_v  = mk(3, 0,1,1,0,0, 2'b00, 0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    memwb_v  = mk(4, 0,0,0,0,0, 2'b00, 1,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    memwr_v  = mk(5, 0,1,0,1,0, 2'b00, 0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    rexec_v  = mk(6, 0,0,0,0,0, 2'b00, 0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
    rwb_v    = mk(7, 0,0,0,0,0, 2'b01, 0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    br1_v    = mk(8, 1,0,0,0,0, 2'b00, 0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
    br0_v    = mk(8, 0,0,0,0,0, 2'b00, 0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
    isub_v   = mk(9, 0,0,0,0,0, 2'b00, 0,0,0,1, 2'b10, 2'b01, 2'b00, 0,0);
    islt_v   = mk(9, 0,0,0,0,0, 2'b00, 0,0,0,1, 2'b10, 2'b11, 2'b00, 0,0);
    iadd_v   = mk(9, 0,0,0,0,0, 2'b00, 0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    iwb_v    = mk(10,0,0,0,0,0, 2'b00, 0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    jump_v   = mk(11,1,0,0,0,0, 2'b00, 0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0);
    jal_v    = mk(12,1,0,0,0,0, 2'b10, 0,1,1,0, 2'b00, 2'b00, 2'b10, 1,0);
    jr_v     = mk(13,1,0,0,0,0, 2'b00, 0,0,0,0, 2'b00, 2'b00, 2'b11, 1,0);
    @(posedge clk);
    #1;
    hold_reset("reset", 2);
    seq = '{fetch_v, decode_v, memadr_v, memrd_v, memwb_v};
    go("lw", 6'b100011, 6'd0, 1'b0, 5);
    go("lw_abort", 6'b100011, 6'd0, 1'b0, 3);
    hold_reset("rst_mid_memrd", 2);
    go("lw_after_rst", 6'b100011, 6'd0, 1'b0, 5);
    seq = '{fetch_v, decode_v, memadr_v, memwr_v};
    go("sw", 6'b101011, 6'd0, 1'b0, 4);
    seq = '{fetch_v, decode_v, rexec_v, rwb_v};
    go("r_add", 6'b000000, 6'b100000, 1'b0, 4);
`ifdef MC_JR_EN
    seq = '{fetch_v, decode_v, jr_v};
    go("jr", 6'b000000, 6'b001000, 1'b0, 3);
`else
    go("r_func08", 6'b000000, 6'b001000, 1'b0, 4);
`endif
    seq = '{fetch_v, decode_v, br1_v};
    go("beq_taken", 6'b000100, 6'd0, 1'b1, 3);
    go("bne_taken", 6'b000101, 6'd0, 1'b0, 3);
    seq = '{fetch_v, decode_v, br0_v};
    go("beq_not", 6'b000100, 6'd0, 1'b0, 3);
    go("bne_not", 6'b000101, 6'd0, 1'b1, 3);
    seq = '{fetch_v, decode_v, isub_v, iwb_v};
    go("subi", 6'b001001, 6'd0, 1'b0, 4);
    seq = '{fetch_v, decode_v, islt_v, iwb_v};
    go("slti", 6'b001010, 6'd0, 1'b0, 4);
    seq = '{fetch_v, decode_v, iadd_v, iwb_v};
    go("addi", 6'b001000, 6'd0, 1'b0, 4);
    seq = '{fetch_v, decode_v, jal_v};
    go("jal", 6'b000011, 6'd0, 1'b0, 3);
    seq = '{fetch_v, decode_v, jump_v};
    go("j", 6'b000010, 6'd0, 1'b0, 3);
    seq = '{fetch_v, ill_v};
    go("illegal_3f", 6'b111111, 6'd0, 1'b0, 2);
    go("illegal_01", 6'b000001, 6'd0, 1'b0, 2);
    seq = '{fetch_v, decode_v, memadr_v, memwr_v};
    go("sw_after_ill", 6'b101011, 6'd0, 1'b0, 4);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
